label_check: RTL and testbench

- ARINC429 receive-side label filter.
- Holds a 256-entry x 1-bit label-enable table, written by the host and indexed by label address.
- Each received 8-bit label is looked up on a read strobe. Label_out reports whether the word with that label is accepted (1) or discarded (0).
- Sits between the ARINC429 receiver shift/decoder and the receive FIFO write logic.

---
 rtl/label_check.sv | 79 +++++++
 tb/tb_label_check.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/label_check.sv
// label_check: ARINC429 receive-side label filter with a 256 x 1 enable table.
// Optional macro LABEL_BITREV_EN: bit-reverse Label_in before lookup.
module label_check #(
    parameter bit DEFAULT_PASS = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Wr,
    input  logic       Clr,
    input  logic       Rd,
    input  logic [7:0] Label_adr,
    input  logic [7:0] Label_in,
    output logic       Label_out,
    output logic       Label_valid,
    output logic [8:0] Enabled_cnt
);

    logic [255:0] r_table;
    logic         r_out;
    logic         r_valid;
    logic [8:0]   r_cnt;

    logic [7:0]   w_idx;
    logic         w_wr_en;
    logic         w_wr_val;
    logic         w_change;
    logic         w_hit;
    logic         w_lookup;

    // Effective lookup index; the ARINC bus may deliver the label LSB-first.
`ifdef LABEL_BITREV_EN
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < 8; i++) begin
            w_idx[i] = Label_in[7-i];
        end
    end
`else
    assign w_idx = Label_in;
`endif

    // Wr dominates Clr; a write of the value already stored changes nothing.
    assign w_wr_en  = Wr | Clr;
    assign w_wr_val = Wr;
    assign w_change = w_wr_en && (r_table[Label_adr] != w_wr_val);

    // Write-first bypass when the host writes the entry being looked up.
    assign w_hit    = w_wr_en && (Label_adr == w_idx);
    assign w_lookup = w_hit ? w_wr_val : r_table[w_idx];

    // Enable table and running count of enabled entries.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_table <= {256{DEFAULT_PASS}};
            r_cnt   <= DEFAULT_PASS ? 9'd256 : 9'd0;
        end else if (w_change) begin
            r_table[Label_adr] <= w_wr_val;
            r_cnt              <= w_wr_val ? r_cnt + 9'd1 : r_cnt - 9'd1;
        end
    end

    // Registered lookup result; holds between reads, valid pulses per read.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= Rd;
            if (Rd) begin
                r_out <= w_lookup;
            end
        end
    end

    assign Label_out   = r_out;
    assign Label_valid = r_valid;
    assign Enabled_cnt = r_cnt;

endmodule

// File: tb/tb_label_check.sv
// tb_label_check: directed vector table, hand sequences and random
// stimulus checked against a behavioural model of the label table.
module tb_label_check;

    logic       Clk = 1'b0;
    logic       Rst, Wr, Clr, Rd;
    logic [7:0] Label_adr, Label_in;
    logic       Label_out, Label_valid;
    logic [8:0] Enabled_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit model [256];
    bit m_out;
    bit m_valid;

    typedef struct {
        bit       rst, wr, clr, rd;
        bit [7:0] adr, idx;
        bit       e_out, e_valid;
        int       e_cnt;
    } vec_t;

    vec_t vecs [15];

    label_check #(.DEFAULT_PASS(1'b0)) dut (
        .Clk(Clk), .Rst(Rst), .Wr(Wr), .Clr(Clr), .Rd(Rd),
        .Label_adr(Label_adr), .Label_in(Label_in),
        .Label_out(Label_out), .Label_valid(Label_valid),
        .Enabled_cnt(Enabled_cnt)
    );

    always #5 Clk = ~Clk;

    // Label_in value that addresses table entry idx (reversal is self-inverse).
    function automatic logic [7:0] eff(input logic [7:0] v);
`ifdef LABEL_BITREV_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
`else
        return v;
`endif
    endfunction

    function automatic int model_cnt();
        int s = 0;
        for (int i = 0; i < 256; i++) s += int'(model[i]);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input bit rst, wr, clr, rd,
                        input bit [7:0] adr, lin);
        bit [7:0] idx;
        Rst = rst; Wr = wr; Clr = clr; Rd = rd;
        Label_adr = adr; Label_in = lin;
        idx = eff(lin);
        if (rst) begin
            for (int i = 0; i < 256; i++) model[i] = 1'b0;
            m_out = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (rd) m_out = (wr || clr) && adr == idx ? wr : model[idx];
            m_valid = rd;
            if (wr) model[adr] = 1'b1;
            else if (clr) model[adr] = 1'b0;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc_model(input string tag, input bit rst, wr, clr,
                             rd, input bit [7:0] adr, lin);
        step(rst, wr, clr, rd, adr, lin);
        check({tag, ".out"}, 32'(Label_out), 32'(m_out));
        check({tag, ".valid"}, 32'(Label_valid), 32'(m_valid));
        check({tag, ".cnt"}, 32'(Enabled_cnt), 32'(model_cnt()));
    endtask

    function automatic vec_t mk(bit rst, wr, clr, rd, bit [7:0] adr, idx,
                                bit eo, ev, int ec);
        vec_t v;
        v.rst = rst; v.wr = wr; v.clr = clr; v.rd = rd;
        v.adr = adr; v.idx = idx;
        v.e_out = eo; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 8'h00, 8'hFF, 0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 8'h05, 8'h00, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 1, 8'h00, 8'h05, 1, 1, 1);
        vecs[6]  = mk(0, 0, 0, 1, 8'h00, 8'h04, 0, 1, 1);
        vecs[7]  = mk(0, 0, 1, 1, 8'h05, 8'h05, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 1, 8'h05, 8'h05, 1, 1, 1);
        vecs[9]  = mk(0, 1, 0, 0, 8'h05, 8'h00, 1, 0, 1);
        vecs[10] = mk(0, 0, 1, 0, 8'h05, 8'h00, 1, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 8'h10, 8'h00, 1, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 8'h00, 8'h10, 1, 1, 1);
        vecs[13] = mk(0, 0, 1, 1, 8'h22, 8'h10, 1, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 8'h00, 8'h11, 0, 1, 1);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].clr, vecs[i].rd,
                 vecs[i].adr, eff(vecs[i].idx));
            check($sformatf("vec%0d.out", i), 32'(Label_out),
                  32'(vecs[i].e_out));
            check($sformatf("vec%0d.valid", i), 32'(Label_valid),
                  32'(vecs[i].e_valid));
            check($sformatf("vec%0d.cnt", i), 32'(Enabled_cnt),
                  32'(vecs[i].e_cnt));
        end

`ifdef LABEL_BITREV_EN
        // LSB-first labels: host address 0xA0 matches received 0x05.
        cyc_model("rev.rst", 1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'hA0, 8'h00);
        step(0, 0, 0, 1, 8'h00, 8'h05);
        check("rev.05", 32'(Label_out), 32'd1);
        step(0, 0, 0, 1, 8'h00, 8'hA0);
        check("rev.A0", 32'(Label_out), 32'd0);
`endif

        // Fill every entry with lookups running alongside.
        cyc_model("fill.rst", 1, 0, 0, 0, 8'h00, 8'h00);
        for (int a = 0; a < 256; a++) begin
            step(0, 1, 0, 1, 8'(a), 8'(255 - a));
            check("fill.cnt", 32'(Enabled_cnt), 32'(a + 1));
        end
        check("fill.full", 32'(Enabled_cnt), 32'd256);
        step(0, 1, 0, 1, 8'h33, 8'h44);
        check("fill.nowrap", 32'(Enabled_cnt), 32'd256);

        // Reset mid-fill while a lookup is requested.
        for (int a = 0; a < 40; a++) begin
            cyc_model("refill", 0, 1, 0, 1, 8'(a * 3), 8'(a * 3));
        end
        step(1, 1, 0, 1, 8'h99, 8'h00);
        check("midrst.cnt", 32'(Enabled_cnt), 32'd0);
        check("midrst.out", 32'(Label_out), 32'd0);
        check("midrst.valid", 32'(Label_valid), 32'd0);
        cyc_model("postrst", 0, 0, 0, 0, 8'h00, 8'h00);

        // Random traffic on a small address window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            bit [7:0] adr, lin;
            adr = 8'($urandom_range(0, 15));
            lin = (($urandom & 1) != 0) ? eff(adr)
                                          : eff(8'($urandom_range(0, 15)));
            cyc_model("rnd", ($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 1) == 0), adr, lin);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
